handshake_constant_burst: RTL
=============================

Name: handshake_constant_burst

Overview:
- Parametrised successor to the single-token handshake constant used in the dataflow netlists.
- Each token accepted on the control channel produces a registered burst of REPEAT output tokens. In MODE 0 every token carries the constant VALUE; in MODE 1 the tokens form a ramp VALUE, VALUE+STRIDE, VALUE+2*STRIDE, and so on.
- The output is registered, so it breaks the combinational valid path between producer and consumer.
- Used wherever the netlist needs an index or offset sequence, or a repeated literal, per control token.

Parameters:
- DATA_WIDTH, 32, width of outs.
- VALUE, 0, DATA_WIDTH-bit constant; the first token of every burst.
- REPEAT, 1, tokens per burst; must be >=1, and REPEAT=0 is an elaboration error.
- MODE, 0, 0 = constant repeat, 1 = arithmetic ramp.
- STRIDE, 1, DATA_WIDTH-bit ramp increment; ignored when MODE=0.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset; all state clears immediately on assertion.
- ctrl_valid  in  1  control token present.
- ctrl_ready  out  1  control token accepted this cycle when high together with ctrl_valid.
- outs  out  DATA_WIDTH  registered token data.
- outs_valid  out  1  registered token valid.
- outs_last  out  1  high with the final token of a burst.
- outs_ready  in  1  consumer ready.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, cnt=0, outs=0, outs_valid=0, outs_last=0, and ctrl_ready is forced to 0 while rst is low.
- After rst deasserts, the first active edge behaves normally; there is no extra idle cycle.
- Internal counter cnt is max(1,$clog2(REPEAT)) bits wide and counts 0..REPEAT-1.
- States are IDLE (no token held) and EMIT (outs_valid=1).
- Handshakes:
  - ctrl_ready = IDLE | (outs_valid & outs_ready & outs_last). This is combinational from outs_ready, and it is the only comb path through the block.
  - An output transfer occurs when outs_valid & outs_ready.
  - A control accept occurs when ctrl_valid & ctrl_ready.
- IDLE, accept: next cycle state=EMIT, outs=VALUE, cnt=0, outs_valid=1, outs_last=(REPEAT==1). Latency from accept to first outs_valid is 1 cycle.
- EMIT, no transfer: outs, outs_valid, outs_last and cnt hold stable. This is mandatory; no data change while stalled.
- EMIT, transfer, not last:
  - cnt increments by 1.
  - outs becomes outs+STRIDE when MODE=1, or stays VALUE when MODE=0.
  - outs_last is set when the new cnt equals REPEAT-1.
- EMIT, transfer of the last token:
  - With a simultaneous control accept: restart the burst, so outs=VALUE, cnt=0, outs_last=(REPEAT==1), and the state stays EMIT. There is no bubble, and back-to-back bursts sustain 1 token/cycle.
  - Without a control accept: state goes to IDLE, outs_valid=0, outs_last=0, and outs holds its last value.
- Ramp arithmetic wraps modulo 2^DATA_WIDTH; there is no saturation or overflow flag.
- ctrl_valid arriving during a non-last EMIT cycle is not accepted (ctrl_ready=0). The producer must hold the token.
- REPEAT=1 with MODE=0 reduces to a one-entry registered constant source with full throughput.
- Reset asserted mid-burst aborts the burst immediately. The remaining tokens are discarded, and the next burst starts from VALUE.

Test Plan:
- DATA_WIDTH=8, VALUE=8'h2A, REPEAT=1, MODE=0, outs_ready=1, ctrl_valid held high 5 cycles → outs=2A on 5 consecutive cycles from cycle 1, outs_last=1 every beat, ctrl_ready=1 every cycle.
- VALUE=8'h10, REPEAT=4, MODE=1, STRIDE=3, single ctrl token, outs_ready=1 → outs 10,13,16,19 on consecutive cycles, outs_last only with 19, then outs_valid=0.
- Same configuration, outs_ready low on cycles 2-4 of the burst → outs frozen at 13 with outs_valid=1 throughout the stall, sequence then completes 16,19, ctrl_ready=0 during the stall.
- VALUE=8'hFE, REPEAT=3, MODE=1, STRIDE=1 → outs FE, FF, 00 (wrap), outs_last with 00.
- REPEAT=2, MODE=0, ctrl_valid continuously high, outs_ready=1 → ctrl_ready pulses on each last beat, outs_valid never drops, 2 tokens per accepted ctrl.
- REPEAT=4, rst pulsed low asynchronously (between clk edges) after the 2nd token → outs_valid=0 and outs=0 immediately, ctrl_ready=0 while low, next ctrl token restarts at VALUE.

Source files
------------

// File: rtl/handshake_constant_burst.sv
// Control-token triggered burst source: each accepted token yields REPEAT registered
// output tokens, either a repeated constant (MODE 0) or an arithmetic ramp (MODE 1).
module handshake_constant_burst #(
    parameter int unsigned                  DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0]        VALUE      = '0,
    parameter int unsigned                  REPEAT     = 1,
    parameter int unsigned                  MODE       = 0,
    parameter logic [DATA_WIDTH-1:0]        STRIDE     = DATA_WIDTH'(1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ctrl_valid,
    output logic                  ctrl_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    output logic                  outs_last,
    input  logic                  outs_ready
);

    localparam int unsigned CNT_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REPEAT - 1);
    localparam logic LAST_AT_START = (REPEAT == 1);

    // Reject illegal configurations at elaboration time.
    if (REPEAT == 0) begin : g_bad_repeat
        $error("handshake_constant_burst: REPEAT must be >= 1");
    end
    if (MODE > 1) begin : g_bad_mode
        $error("handshake_constant_burst: MODE must be 0 or 1");
    end

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt, cnt_inc;
    logic [DATA_WIDTH-1:0]   outs_nxt;
    logic                    valid_nxt;
    logic                    last_nxt;
    logic                    xfer;
    logic                    accept;

    // Only combinational path: a new token may enter on the beat the last one leaves.
    assign ctrl_ready = rst & ((state == IDLE) | (outs_valid & outs_ready & outs_last));
    assign xfer       = outs_valid & outs_ready;
    assign accept     = ctrl_valid & ctrl_ready;
    assign cnt_inc    = cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            outs       <= '0;
            outs_valid <= 1'b0;
            outs_last  <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            outs       <= outs_nxt;
            outs_valid <= valid_nxt;
            outs_last  <= last_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        outs_nxt  = outs;
        valid_nxt = outs_valid;
        last_nxt  = outs_last;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = EMIT;
                    cnt_nxt   = '0;
                    outs_nxt  = VALUE;
                    valid_nxt = 1'b1;
                    last_nxt  = LAST_AT_START;
                end
            end
            EMIT: begin
                // Stalled beats fall through and hold every output register.
                if (xfer) begin
                    if (outs_last) begin
                        if (accept) begin
                            cnt_nxt  = '0;
                            outs_nxt = VALUE;
                            last_nxt = LAST_AT_START;
                        end else begin
                            state_nxt = IDLE;
                            valid_nxt = 1'b0;
                            last_nxt  = 1'b0;
                        end
                    end else begin
                        cnt_nxt  = cnt_inc;
                        outs_nxt = (MODE == 1) ? outs + STRIDE : VALUE;
                        last_nxt = (cnt_inc == CNT_LAST);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                valid_nxt = 1'b0;
                last_nxt  = 1'b0;
            end
        endcase
    end

endmodule
